// File: rtl/if_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package if_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_slot.sv
// IF/ID output register: one entry with load, flush and drain; flush wins over load,
// load wins over drain.
module if_id_slot
  import if_pkg::*;
#(
  parameter type data_t = if_id_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  logic  ready,
  input  data_t data_in,
  output logic  valid,
  output data_t data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      // NOTE: the payload is reset as well so id_instr/id_pc read zero out of reset.
      data  <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and
// holds the fetched word for decode. Define FETCH_PERF_EN to add perf counters.
module fetch_stage
  import if_pkg::*;
#(
  parameter int                      ADDR_W   = if_pkg::ADDR_W,
  parameter int                      INSTR_W  = if_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_kill_cnt
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
  } slot_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              grant;
  logic              resp;
  logic              load;
  slot_t             slot_in, slot_out;

  // Gated by reset so no request leaks out while reset is held.
  assign imem_req  = reset && (state_q == FETCH) && (!id_valid || id_ready) && !kill_q;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign resp      = (state_q == WAIT) && imem_rvalid;
  assign load      = resp && !kill_q && !br_taken;

  assign slot_in = '{instr: imem_rdata, pc: pc_q, pc_plus4: pc_q + PC_STEP};

  always_comb begin
    // NOTE: defaults first, so no path leaves a target unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    if (br_taken) begin
      pc_d = {br_target[ADDR_W-1:2], 2'b00};
      case (state_q)
        FETCH: if (grant) begin
          state_d = WAIT;
          kill_d  = 1'b1;
        end
        WAIT: if (imem_rvalid) begin
          state_d = FETCH;
          kill_d  = 1'b0;
        end else begin
          kill_d = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: if (grant) state_d = WAIT;
        WAIT: if (imem_rvalid) begin
          state_d = FETCH;
          kill_d  = 1'b0;
          if (!kill_q) pc_d = pc_q + PC_STEP;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  if_id_slot #(.data_t(slot_t)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .flush   (br_taken),
    .ready   (id_ready),
    .data_in (slot_in),
    .valid   (id_valid),
    .data    (slot_out)
  );

  assign id_instr    = slot_out.instr;
  assign id_pc       = slot_out.pc;
  assign id_pc_plus4 = slot_out.pc_plus4;

  // Requests issue only with the slot empty or draining, so a load never overwrites.
  slot_free_at_load: assert property (@(posedge clk) disable iff (!reset)
    load |-> (!id_valid || id_ready));

`ifdef FETCH_PERF_EN
  logic drop;
  assign drop = resp && (kill_q || br_taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then randomized traffic
// against a transaction-level model. Honours FETCH_PERF_EN for the counter ports.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [63:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // Stimulus knobs and the bench's own memory.
  int          gnt_prob, ready_prob, br_prob, dly_min, dly_max;
  logic        mem_busy;
  logic [63:0] mem_addr;
  int          mem_cnt;
  logic        last_grant, last_resp;
  logic [63:0] last_addr;

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(3))
      0:       t = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(15))};
      1:       t = {$urandom(), $urandom()};
      default: t = 64'($urandom_range(1023));
    endcase
    return t;
  endfunction

  task automatic drive();
    if (last_resp) mem_busy = 1'b0;
    if (last_grant) begin
      mem_busy = 1'b1;
      mem_addr = last_addr;
      mem_cnt  = int'($urandom_range(dly_max, dly_min));
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
    imem_gnt  = int'($urandom_range(99)) < gnt_prob;
    id_ready  = int'($urandom_range(99)) < ready_prob;
    br_taken  = int'($urandom_range(99)) < br_prob;
    br_target = rand_target();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  // Transaction-level reference: the architectural next PC, one outstanding
  // request (with its address and whether a redirect orphaned it), and the slot.
  logic        m_valid, m_out, m_out_killed, exp_req, m_grant, m_resp;
  logic [31:0] m_instr, m_fetch_cnt, m_kill_cnt;
  logic [63:0] m_pc, m_next_pc, m_out_addr;

  always @(negedge clk) begin
    last_resp = imem_rvalid;
    if (!reset) begin
      check("req_in_reset", {63'd0, imem_req}, 64'd0);
      check("valid_in_reset", {63'd0, id_valid}, 64'd0);
      last_grant   = 1'b0;
      m_valid      = 1'b0;
      m_out        = 1'b0;
      m_out_killed = 1'b0;
      m_next_pc    = 64'd0;
      m_fetch_cnt  = 32'd0;
      m_kill_cnt   = 32'd0;
    end else begin
      exp_req = !m_out && (!m_valid || id_ready);
      check("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, m_next_pc);
      check("id_valid", {63'd0, id_valid}, {63'd0, m_valid});
      if (m_valid) begin
        check("id_instr", {32'd0, id_instr}, {32'd0, m_instr});
        check("id_pc", id_pc, m_pc);
        check("id_pc_plus4", id_pc_plus4, m_pc + 64'd4);
      end
`ifdef FETCH_PERF_EN
      check("perf_fetch_cnt", {32'd0, perf_fetch_cnt}, {32'd0, m_fetch_cnt});
      check("perf_kill_cnt", {32'd0, perf_kill_cnt}, {32'd0, m_kill_cnt});
`endif
      last_grant = imem_req && imem_gnt;
      last_addr  = imem_addr;

      m_grant = exp_req && imem_gnt;
      m_resp  = m_out && imem_rvalid;
      if (br_taken) begin
        m_next_pc = {br_target[63:2], 2'b00};
        m_valid   = 1'b0;
        if (m_resp) begin
          m_out = 1'b0;
          m_kill_cnt++;
        end else if (m_out) begin
          m_out_killed = 1'b1;
        end
        if (m_grant) begin
          m_out        = 1'b1;
          m_out_killed = 1'b1;
        end
      end else begin
        if (m_valid && id_ready) m_valid = 1'b0;
        if (m_resp) begin
          m_out = 1'b0;
          if (m_out_killed) m_kill_cnt++;
          else begin
            m_valid   = 1'b1;
            m_instr   = mem_word(m_out_addr);
            m_pc      = m_out_addr;
            m_next_pc = m_out_addr + 64'd4;
            m_fetch_cnt++;
          end
        end
        if (m_grant) begin
          m_out        = 1'b1;
          m_out_addr   = m_next_pc;
          m_out_killed = 1'b0;
        end
      end
    end
  end

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    br_taken = 1'b0; br_target = '0; id_ready = 1'b0;
    gnt_prob = 100; ready_prob = 100; br_prob = 0; dly_min = 1; dly_max = 1;
    mem_busy = 1'b0; mem_addr = '0; mem_cnt = 0;
    last_grant = 1'b0; last_resp = 1'b0; last_addr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_instr", {32'd0, id_instr}, 64'd0);
    check("rst_id_pc", id_pc, 64'd0);
    check("rst_id_pc_plus4", id_pc_plus4, 64'd0);

    // Zero-wait memory: requests at 0x0, 0x4, 0x8 every other cycle.
    step(); reset = 1'b1;                                     // cycle 0
    @(negedge clk);
    check("c0_req", {63'd0, imem_req}, 64'd1);
    check("c0_addr", imem_addr, 64'h0);
    step(); step();                                           // cycle 2
    @(negedge clk);
    check("c2_addr", imem_addr, 64'h4);
    check("c2_id_pc", id_pc, 64'h0);
    check("c2_id_pc_plus4", id_pc_plus4, 64'h4);
    check("c2_id_instr", {32'd0, id_instr}, {32'd0, mem_word(64'h0)});

    // Decode stalls with id_pc=0x4 held in the slot.
    step(); ready_prob = 0;
    for (int c = 4; c <= 8; c++) begin
      step();
      @(negedge clk);
      check("stall_req", {63'd0, imem_req}, 64'd0);
      check("stall_id_pc", id_pc, 64'h4);
      check("stall_id_instr", {32'd0, id_instr}, {32'd0, mem_word(64'h4)});
    end
    ready_prob = 100;
    step();                                                   // cycle 9
    @(negedge clk);
    check("resume_req", {63'd0, imem_req}, 64'd1);
    check("resume_addr", imem_addr, 64'h8);

    // Redirect during WAIT, response two cycles later.
    dly_min = 3; dly_max = 3;
    step(); br_taken = 1'b1; br_target = 64'h103;             // cycle 10
    dly_min = 1; dly_max = 1;
    step(); step();                                           // cycle 12: stale rvalid
    @(negedge clk);
    check("kill_valid", {63'd0, id_valid}, 64'd0);
    step();                                                   // cycle 13
    @(negedge clk);
    check("kill_valid2", {63'd0, id_valid}, 64'd0);
    check("redirect_addr", imem_addr, 64'h100);

    // Redirect in the same cycle as rvalid.
    step(); br_taken = 1'b1; br_target = 64'h103;             // cycle 14
    step();                                                   // cycle 15
    @(negedge clk);
    check("same_cycle_valid", {63'd0, id_valid}, 64'd0);
    check("same_cycle_addr", imem_addr, 64'h100);
`ifdef FETCH_PERF_EN
    check("perf_kill_lit", {32'd0, perf_kill_cnt}, 64'd2);
    check("perf_fetch_lit", {32'd0, perf_fetch_cnt}, 64'd2);
`endif

    // PC wrap at the top of the address space.
    step(); br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFE;  // cycle 16
    step();                                                   // cycle 17
    @(negedge clk);
    check("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); step();                                           // cycle 19
    @(negedge clk);
    check("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_id_pc_plus4", id_pc_plus4, 64'h0);
    check("wrap_next_addr", imem_addr, 64'h0);

    // Asynchronous reset in WAIT; the stale response lands after release.
    dly_min = 4; dly_max = 4;
    step(); #2 reset = 1'b0;                                  // cycle 20
    @(negedge clk);
    check("async_rst_req", {63'd0, imem_req}, 64'd0);
    check("async_rst_valid", {63'd0, id_valid}, 64'd0);
    dly_min = 1; dly_max = 1;
    step(); gnt_prob = 0;
    step(); reset = 1'b1;                                     // cycle 22
    @(negedge clk);
    check("post_rst_addr", imem_addr, 64'h0);
    step();                                                   // cycle 23: stale rvalid
    gnt_prob = 100;
    step();                                                   // cycle 24
    @(negedge clk);
    check("stale_ignored", {63'd0, id_valid}, 64'd0);
    check("post_rst_req", {63'd0, imem_req}, 64'd1);
`ifdef FETCH_PERF_EN
    check("perf_fetch_rst", {32'd0, perf_fetch_cnt}, 64'd0);
    check("perf_kill_rst", {32'd0, perf_kill_cnt}, 64'd0);
`endif
    step(); step();                                           // cycle 26
    @(negedge clk);
    check("post_rst_load", id_pc, 64'h0);

    // Randomized traffic with one mid-run asynchronous reset.
    gnt_prob = 70; ready_prob = 70; br_prob = 8; dly_min = 1; dly_max = 4;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i == 1500) #3 reset = 1'b0;
      if (i == 1502) reset = 1'b1;
    end
    br_prob = 0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that sits directly upstream of decode.
- Owns the PC and drives the instruction memory through a req/gnt/rvalid handshake with one request outstanding.
- Holds each fetched instruction in an IF/ID output slot until decode takes it.
- Accepts branch redirects from downstream: flushes the slot and discards any in-flight response.

Parameters:
- ADDR_W, 64, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 64'h0, PC value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_gnt  input  1  request accepted this cycle when imem_req&&imem_gnt.
- imem_rvalid  input  1  response valid; in order, at least 1 cycle after grant.
- imem_rdata  input  INSTR_W  instruction word, valid with imem_rvalid.
- br_taken  input  1  redirect pulse from downstream.
- br_target  input  ADDR_W  redirect address; bits [1:0] forced to 0.
- id_valid  output  1  output slot holds an instruction.
- id_ready  input  1  decode consumes the slot when id_valid&&id_ready.
- id_instr  output  INSTR_W  fetched instruction.
- id_pc  output  ADDR_W  address of id_instr.
- id_pc_plus4  output  ADDR_W  id_pc+4, wrap modulo 2^ADDR_W.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, kill=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, imem_req=0 during reset.
- Reset is asynchronous; all state returns to reset values mid-operation.
- A response arriving in FETCH (e.g. stale after reset) is ignored.
- State FETCH:
  - imem_req = (!id_valid || id_ready) && !kill.
  - On grant: go to WAIT.
  - Otherwise: hold the request; imem_addr stays stable until granted.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=1: drop the data, clear kill, go to FETCH.
  - On imem_rvalid with kill=0: id_instr=rdata, id_pc=pc, id_pc_plus4=pc+4, id_valid=1, pc=pc+4, go to FETCH.
- Slot free at response time is guaranteed because issue requires the slot empty or draining. The implementation must assert this.
- Slot drain: id_valid clears on id_valid&&id_ready when no load occurs that cycle.
- br_taken has highest priority on the edge:
  - pc = {br_target[ADDR_W-1:2],2'b00}.
  - id_valid = 0 (flush).
  - If state==WAIT and no rvalid in this cycle: kill=1 and remain in WAIT.
  - If state==WAIT and rvalid in this cycle: the response is dropped, go to FETCH.
  - If state==FETCH and grant in this cycle: go to WAIT with kill=1.
  - Otherwise: stay in FETCH.
- br_taken overrides a simultaneous id_ready consume or load.
- PC arithmetic: unsigned, wraps at 2^ADDR_W (0xFFFF_FFFF_FFFF_FFFC+4 gives 0).
- Throughput with zero-wait memory (gnt=1, rvalid one cycle later): one instruction per 2 cycles.
- Latency: grant to id_valid equals the rvalid delay plus 1 edge.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs, each 32-bit, reset to 0, wrapping at 2^32:
  - perf_fetch_cnt: increments per loaded instruction.
  - perf_kill_cnt: increments per dropped response.
- When undefined: the ports and counters are absent, with no other behavioural difference.

Decomposition:
- Package if_pkg holds:
  - ADDR_W and INSTR_W default constants.
  - fetch_state_t enum {FETCH, WAIT}.
  - if_id_t struct {instr, pc, pc_plus4}.
- One natural sub-module: if_id_slot, the output register with load, flush and drain.
- PC increment stays inline.

Test Plan:
- Reset release, gnt=1, rvalid 1 cycle after grant → addresses 0x0, 0x4, 0x8 requested every 2 cycles; id_pc matches, id_pc_plus4=id_pc+4.
- id_ready=0 for 5 cycles with slot full (id_pc=0x4) → imem_req=0; id_instr stable; next request 0x8 issued the cycle id_ready returns.
- br_taken with target 0x103 during WAIT, rvalid 2 cycles later → response dropped, id_valid stays 0, next imem_addr=0x100.
- br_taken in the same cycle as rvalid → data dropped, id_valid=0, next fetch 0x100; perf_kill_cnt+1 with FETCH_PERF_EN.
- pc=0xFFFF_FFFF_FFFF_FFFC fetch → id_pc_plus4=0, next imem_addr=0x0.
- Reset asserted asynchronously in WAIT, then stale rvalid after release → ignored; first request at RESET_PC; counters 0.
